// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared AES-128 control constants and round sequencer state type
// Purpose: constants and the sequencer state enum shared by the encryptor top,
//          the key expander and the round sequencer.
// Ports:   none (package)
package aes_ctrl_pkg;

  localparam int AES_NR         = 10;
  localparam int AES_RK_W       = 4;
  localparam int AES_KX_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYX   = 3'd1,
    ST_ROUND0 = 3'd2,
    ST_ROUND  = 3'd3,
    ST_FINAL  = 3'd4,
    ST_DONE   = 3'd5
  } aes_seq_state_e;

endpackage

// File: rtl/aes_kx_timer.sv
// rtl/aes_kx_timer.sv - cycle timer bounding the wait for the key expander
// Purpose: counts cycles spent waiting for key expansion; flags expiry on the
//          last permitted cycle and holds there until reloaded.
// Ports:
//   clk      in  1  clock, rising edge
//   rst      in  1  asynchronous, active-low reset
//   load     in  1  clear the count (entry into the wait)
//   en       in  1  count this cycle
//   expired  out 1  count has reached KX_TIMEOUT-1
module aes_kx_timer
  import aes_ctrl_pkg::*;
#(
  parameter int KX_TIMEOUT = AES_KX_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int            TW   = (KX_TIMEOUT > 1) ? $clog2(KX_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(KX_TIMEOUT - 1);

  logic [TW-1:0] count;

  // Saturates at LAST so a stalled enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - control FSM stepping the iterative AES-128 round datapath
// Purpose: caches round-key validity, launches key expansion only when needed,
//          then sequences initial AddRoundKey, NR-1 full rounds and the final
//          round. All outputs are registered (decoded from the next state).
// Ports:
//   clk       in   1     clock, rising edge
//   rst       in   1     asynchronous, active-low reset
//   start     in   1     encrypt one block (sampled only in IDLE)
//   key_load  in   1     new key presented; invalidates cached round keys
//   kx_ready  in   1     key expander finished all round keys
//   kx_start  out  1     one-cycle pulse: begin key expansion
//   ld_state  out  1     load plaintext XOR rk[0]
//   sel_src   out  1     0 = plaintext path, 1 = state register path
//   mix_en    out  1     include MixColumns this round
//   state_en  out  1     datapath state register write enable
//   rk_idx    out  RK_W  round-key index
//   busy      out  1     high from leaving IDLE through DONE
//   done      out  1     one-cycle pulse: ciphertext valid
//   err       out  1     one-cycle pulse: key expansion timed out
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NR         = AES_NR,
  parameter int RK_W       = AES_RK_W,
  parameter int KX_TIMEOUT = AES_KX_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            key_load,
  input  logic            kx_ready,
  output logic            kx_start,
  output logic            ld_state,
  output logic            sel_src,
  output logic            mix_en,
  output logic            state_en,
  output logic [RK_W-1:0] rk_idx,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [RK_W-1:0] RK_LAST   = RK_W'(NR);
  localparam logic [RK_W-1:0] RK_PENULT = RK_W'(NR - 1);

  aes_seq_state_e  state, state_d;
  logic [RK_W-1:0] rnd, rnd_d;
  logic            key_valid, key_valid_d;
  logic            pend_inv, pend_inv_d;
  logic            kx_expired, kx_timer_load, err_d;

  aes_kx_timer #(
    .KX_TIMEOUT (KX_TIMEOUT)
  ) u_kx_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (kx_timer_load),
    .en      (state == ST_KEYX),
    .expired (kx_expired)
  );

  always_comb begin
    state_d       = state;
    rnd_d         = rnd;
    key_valid_d   = key_valid;
    pend_inv_d    = pend_inv;
    kx_timer_load = 1'b0;
    err_d         = 1'b0;

    // A key change mid-block must not disturb the block in flight; remember
    // it and drop the cached keys once the block is out.
    if (key_load && (state != ST_IDLE)) begin
      pend_inv_d = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (key_load) begin
          key_valid_d = 1'b0;
        end
        if (start) begin
          if (key_valid && !key_load) begin
            state_d = ST_ROUND0;
          end else begin
            state_d       = ST_KEYX;
            kx_timer_load = 1'b1;
          end
        end
      end
      ST_KEYX: begin
        if (kx_ready) begin
          key_valid_d = 1'b1;
          state_d     = ST_ROUND0;
        end else if (kx_expired) begin
          key_valid_d = 1'b0;
          pend_inv_d  = 1'b0;
          err_d       = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_ROUND0: begin
        if (NR > 1) begin
          state_d = ST_ROUND;
          rnd_d   = RK_W'(1);
        end else begin
          state_d = ST_FINAL;
          rnd_d   = RK_LAST;
        end
      end
      ST_ROUND: begin
        if (rnd == RK_PENULT) begin
          state_d = ST_FINAL;
          rnd_d   = RK_LAST;
        end else begin
          rnd_d = rnd + 1'b1;
        end
      end
      ST_FINAL: begin
        state_d = ST_DONE;
        rnd_d   = '0;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        // key_load landing in the DONE cycle itself also counts as pending.
        if (pend_inv || key_load) begin
          key_valid_d = 1'b0;
        end
        pend_inv_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        rnd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      rnd       <= '0;
      key_valid <= 1'b0;
      pend_inv  <= 1'b0;
      kx_start  <= 1'b0;
      ld_state  <= 1'b0;
      sel_src   <= 1'b0;
      mix_en    <= 1'b0;
      state_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      rnd       <= rnd_d;
      key_valid <= key_valid_d;
      pend_inv  <= pend_inv_d;
      kx_start  <= kx_timer_load;
      ld_state  <= (state_d == ST_ROUND0);
      sel_src   <= (state_d == ST_ROUND) || (state_d == ST_FINAL);
      mix_en    <= (state_d == ST_ROUND);
      state_en  <= (state_d == ST_ROUND0) || (state_d == ST_ROUND) || (state_d == ST_FINAL);
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_DONE);
      err       <= err_d;
    end
  end

  // The round counter is itself the registered key index.
  assign rk_idx = rnd;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - randomized self-checking bench for aes_round_sequencer
module tb_aes_round_sequencer;
  import aes_ctrl_pkg::*;

  localparam int NR    = AES_NR;
  localparam int RK_W  = AES_RK_W;
  localparam int KX_TO = AES_KX_TIMEOUT;

  logic            clk = 1'b0;
  logic            rst, start, key_load, kx_ready;
  logic            kx_start, ld_state, sel_src, mix_en, state_en, busy, done, err;
  logic [RK_W-1:0] rk_idx;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: block progress as a step index (-1 idle, 0..NR rounds,
  // NR+1 completion), plus key-expansion wait and key cache flags.
  int m_run;
  bit m_kx;
  int m_kx_cyc;
  bit m_kv, m_pend, m_err, m_kxs;

  always #5 clk = ~clk;

  aes_round_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_load (key_load),
    .kx_ready (kx_ready),
    .kx_start (kx_start),
    .ld_state (ld_state),
    .sel_src  (sel_src),
    .mix_en   (mix_en),
    .state_en (state_en),
    .rk_idx   (rk_idx),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = -1; m_kx = 0; m_kx_cyc = 0;
    m_kv = 0; m_pend = 0; m_err = 0; m_kxs = 0;
  endtask

  task automatic model_edge();
    m_err = 0;
    m_kxs = 0;
    if (m_kx) begin
      if (key_load) m_pend = 1;
      if (kx_ready) begin
        m_kv = 1; m_kx = 0; m_run = 0;
      end else if (m_kx_cyc == KX_TO - 1) begin
        m_kx = 0; m_kv = 0; m_pend = 0; m_err = 1;
      end else begin
        m_kx_cyc++;
      end
    end else if (m_run >= 0) begin
      if (key_load) m_pend = 1;
      if (m_run == NR + 1) begin
        m_run = -1;
        if (m_pend) m_kv = 0;
        m_pend = 0;
      end else begin
        m_run++;
      end
    end else begin
      if (start && m_kv && !key_load) begin
        m_run = 0;
      end else if (start) begin
        m_kx = 1; m_kx_cyc = 0; m_kxs = 1; m_kv = 0;
      end else if (key_load) begin
        m_kv = 0;
      end
    end
  endtask

  task automatic compare_all();
    bit rnd_active;
    rnd_active = (m_run >= 0) && (m_run <= NR);
    check("busy",     32'(busy),     32'(m_kx || (m_run >= 0)));
    check("kx_start", 32'(kx_start), 32'(m_kxs));
    check("err",      32'(err),      32'(m_err));
    check("done",     32'(done),     32'(m_run == NR + 1));
    check("state_en", 32'(state_en), 32'(rnd_active));
    check("ld_state", 32'(ld_state), 32'(m_run == 0));
    check("sel_src",  32'(sel_src),  32'(rnd_active && (m_run >= 1)));
    check("mix_en",   32'(mix_en),   32'((m_run >= 1) && (m_run < NR)));
    check("rk_idx",   32'(rk_idx),   rnd_active ? 32'(m_run) : 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Called #1 after an edge; reset pulse fits inside the cycle.
  task automatic async_reset();
    #3 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2 rst = 1'b1;
  endtask

  task automatic run_random(input int n, input int rdy_pct, input int rst_pct);
    for (int i = 0; i < n; i++) begin
      start    = ($urandom_range(0, 5) == 0);
      key_load = ($urandom_range(0, 24) == 0);
      kx_ready = ($urandom_range(0, 99) < rdy_pct);
      cycle();
      if ($urandom_range(0, 99) < rst_pct) async_reset();
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; key_load = 1'b0; kx_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;

    // Uncached first block: key_load with start, expander ready after 5 cycles.
    key_load = 1'b1; start = 1'b1;
    cycle();
    key_load = 1'b0; start = 1'b0;
    repeat (4) cycle();
    kx_ready = 1'b1;
    cycle();
    kx_ready = 1'b0;
    repeat (14) cycle();

    // Cached block with a stray start mid-round and a key_load at rk_idx 6.
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    key_load = 1'b1;
    cycle();
    key_load = 1'b0;
    repeat (10) cycle();

    // Expander never answers: timeout path.
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (KX_TO + 4) cycle();

    // Reset in the middle of a block.
    kx_ready = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    kx_ready = 1'b0;
    async_reset();
    repeat (3) cycle();

    run_random(1500, 25, 0);
    run_random(400, 0, 0);
    run_random(1000, 30, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
